// File: rtl/run_scan_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_scan_ctrl_if : word/result handshake and detector pins of run_scan_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
interface run_scan_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_word;
   logic             abort;
   logic             det_rst;
   logic             det_data;
   logic             det_hit;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic [CNT_W-1:0] out_first;
   logic             out_any;

   modport master (
      output in_valid, in_word, abort, det_hit, out_ready,
      input  in_ready, det_rst, det_data, out_valid, out_count, out_first, out_any
   );

   modport slave (
      input  in_valid, in_word, abort, det_hit, out_ready,
      output in_ready, det_rst, det_data, out_valid, out_count, out_first, out_any
   );
endinterface
`default_nettype wire

// File: rtl/run_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_scan_ctrl : streams a word MSB-first into the run detector, counts hits
// Revision: 1.0
// ---------------------------------------------------------------------------
module run_scan_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   run_scan_ctrl_if.slave bus
);
   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_shift = 2'd1;
   localparam logic [1:0] c_st_drain = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CNT_W-1:0] r_k;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_first;
   logic             r_any;

   // Detector output trails its data by one cycle, so the hit seen at k is bit k-1.
   logic w_hit_valid;
   assign w_hit_valid = bus.det_hit && (r_k != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
         r_sreg  <= '0;
         r_k     <= '0;
         r_count <= '0;
         r_first <= '0;
         r_any   <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.in_valid) begin
                  r_sreg  <= bus.in_word;
                  r_k     <= '0;
                  r_count <= '0;
                  r_first <= '0;
                  r_any   <= 1'b0;
                  r_state <= c_st_shift;
               end
            end
            c_st_shift, c_st_drain: begin
               if (bus.abort) begin
                  r_k     <= '0;
                  r_count <= '0;
                  r_first <= '0;
                  r_any   <= 1'b0;
                  r_state <= c_st_idle;
               end else begin
                  if (w_hit_valid) begin
                     r_count <= r_count + c_one;
                     if (!r_any) begin
                        r_first <= r_k - c_one;
                        r_any   <= 1'b1;
                     end
                  end
                  if (r_state == c_st_shift) begin
                     r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                     r_k    <= r_k + c_one;
                     if (r_k == c_last) begin
                        r_state <= c_st_drain;
                     end
                  end else begin
                     r_state <= c_st_done;
                  end
               end
            end
            c_st_done: begin
               if (bus.out_ready) begin
                  r_state <= c_st_idle;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == c_st_idle);
   assign bus.det_rst   = (r_state == c_st_idle) || (r_state == c_st_done);
   assign bus.det_data  = (r_state == c_st_shift) ? r_sreg[WIDTH-1] : 1'b0;
   assign bus.out_valid = (r_state == c_st_done);
   assign bus.out_count = r_count;
   assign bus.out_first = r_first;
   assign bus.out_any   = r_any;
endmodule
`default_nettype wire

// File: tb/tb_run_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_scan_ctrl : directed bench for run_scan_ctrl with a 000/111 detector
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_run_scan_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   run_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   run_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Non-overlapping Moore run detector: 0 start, 1/2 zeros, 3/4 ones, 5 hit.
   logic [2:0] r_det = 3'd0;
   always @(posedge clk) begin
      if (bus.det_rst) r_det <= 3'd0;
      else begin
         case (r_det)
            3'd1:    r_det <= bus.det_data ? 3'd3 : 3'd2;
            3'd2:    r_det <= bus.det_data ? 3'd3 : 3'd5;
            3'd3:    r_det <= bus.det_data ? 3'd4 : 3'd1;
            3'd4:    r_det <= bus.det_data ? 3'd5 : 3'd1;
            default: r_det <= bus.det_data ? 3'd3 : 3'd1;
         endcase
      end
   end
   assign bus.det_hit = (r_det == 3'd5);

   int pass_cnt = 0;
   int total    = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && bus.in_ready !== 1'b1; i++) tick();
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL idle_timeout in_ready=%b required 1", bus.in_ready);
      else pass_cnt++;
   endtask

   task automatic scan_word(input logic [WIDTH-1:0] word, input logic [CNT_W-1:0] ec,
                            input logic [CNT_W-1:0] ef, input logic ea, input string nm);
      logic exp_d;
      wait_idle();
      bus.in_word  = word;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_word  = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         exp_d = (i < WIDTH) ? word[WIDTH-1-i] : 1'b0;
         total++;
         if (bus.det_data !== exp_d || bus.det_rst !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL %s_stream k=%0d data=%b rst=%b ov=%b ir=%b required data=%b rst=0 ov=0 ir=0",
                     nm, i, bus.det_data, bus.det_rst, bus.out_valid, bus.in_ready, exp_d);
         else pass_cnt++;
         tick();
      end
      total++;
      if (bus.out_valid !== 1'b1) $display("FAIL %s_latency out_valid=%b required 1", nm, bus.out_valid);
      else pass_cnt++;
      total++;
      if (bus.out_count !== ec) $display("FAIL %s_count got %0d required %0d", nm, bus.out_count, ec);
      else pass_cnt++;
      total++;
      if (bus.out_first !== ef) $display("FAIL %s_first got %0d required %0d", nm, bus.out_first, ef);
      else pass_cnt++;
      total++;
      if (bus.out_any !== ea) $display("FAIL %s_any got %b required %b", nm, bus.out_any, ea);
      else pass_cnt++;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL %s_release out_valid=%b in_ready=%b required 0 1", nm, bus.out_valid, bus.in_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      total++;
      if (bus.in_ready !== 1'b1 || bus.det_rst !== 1'b1 || bus.det_data !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL reset_ctrl ir=%b dr=%b dd=%b ov=%b required 1 1 0 0",
                  bus.in_ready, bus.det_rst, bus.det_data, bus.out_valid);
      else pass_cnt++;
      total++;
      if (bus.out_count !== '0 || bus.out_first !== '0 || bus.out_any !== 1'b0)
         $display("FAIL reset_result count=%0d first=%0d any=%b required 0 0 0",
                  bus.out_count, bus.out_first, bus.out_any);
      else pass_cnt++;
   endtask

   task automatic test_runs();
      scan_word(8'h00, 4'd2, 4'd2, 1'b1, "zeros");
      scan_word(8'hFF, 4'd2, 4'd2, 1'b1, "ones");
      scan_word(8'b11100011, 4'd2, 4'd2, 1'b1, "mixed");
      scan_word(8'h55, 4'd0, 4'd0, 1'b0, "alt");
      scan_word(8'b01000100, 4'd1, 4'd4, 1'b1, "single");
   endtask

   task automatic test_back_to_back();
      wait_idle();
      bus.in_word  = 8'h00;
      bus.in_valid = 1'b1;
      tick();
      bus.in_word = 8'hFF;
      repeat (WIDTH + 1) tick();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_count !== 4'd2 ||
             bus.out_first !== 4'd2 || bus.out_any !== 1'b1)
            $display("FAIL b2b_hold c=%0d ov=%b ir=%b count=%0d first=%0d any=%b required 1 0 2 2 1",
                     i, bus.out_valid, bus.in_ready, bus.out_count, bus.out_first, bus.out_any);
         else pass_cnt++;
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL b2b_release ir=%b ov=%b required 1 0", bus.in_ready, bus.out_valid);
      else pass_cnt++;
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.in_ready !== 1'b0) $display("FAIL b2b_accept in_ready=%b required 0", bus.in_ready);
      else pass_cnt++;
      repeat (WIDTH + 1) tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_count !== 4'd2 || bus.out_first !== 4'd2 || bus.out_any !== 1'b1)
         $display("FAIL b2b_second ov=%b count=%0d first=%0d any=%b required 1 2 2 1",
                  bus.out_valid, bus.out_count, bus.out_first, bus.out_any);
      else pass_cnt++;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_abort();
      logic seen_valid;
      wait_idle();
      bus.in_word  = 8'h00;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.det_rst !== 1'b1)
         $display("FAIL abort_idle ir=%b ov=%b dr=%b required 1 0 1", bus.in_ready, bus.out_valid, bus.det_rst);
      else pass_cnt++;
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid === 1'b1) seen_valid = 1'b1;
         tick();
      end
      total++;
      if (seen_valid !== 1'b0) $display("FAIL abort_no_result out_valid seen=%b required 0", seen_valid);
      else pass_cnt++;
      scan_word(8'h55, 4'd0, 4'd0, 1'b0, "post_abort");
   endtask

   task automatic test_mid_reset();
      wait_idle();
      bus.in_word  = 8'h00;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1 || bus.det_rst !== 1'b1 || bus.det_data !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL midrst_ctrl ir=%b dr=%b dd=%b ov=%b required 1 1 0 0",
                  bus.in_ready, bus.det_rst, bus.det_data, bus.out_valid);
      else pass_cnt++;
      total++;
      if (bus.out_count !== '0 || bus.out_first !== '0 || bus.out_any !== 1'b0)
         $display("FAIL midrst_result count=%0d first=%0d any=%b required 0 0 0",
                  bus.out_count, bus.out_first, bus.out_any);
      else pass_cnt++;
      tick();
      rst = 1'b1;
      tick();
      scan_word(8'b11100011, 4'd2, 4'd2, 1'b1, "post_rst");
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_word   = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      test_reset();
      rst = 1'b1;
      tick();
      test_runs();
      test_back_to_back();
      test_abort();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
